// File: rtl/alu_pkg.sv
// Shared constants for the two-stage Hack-style ALU pipeline: default width,
// control-word bit positions (zx..no, MSB first) and named Hack control codes.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef logic [5:0] ctl_t;

  localparam int CTL_ZX = 5;
  localparam int CTL_NX = 4;
  localparam int CTL_ZY = 3;
  localparam int CTL_NY = 2;
  localparam int CTL_F  = 1;
  localparam int CTL_NO = 0;

  localparam ctl_t HACK_ZERO      = 6'b101010;
  localparam ctl_t HACK_ONE       = 6'b111111;
  localparam ctl_t HACK_NEG_ONE   = 6'b111010;
  localparam ctl_t HACK_X         = 6'b001100;
  localparam ctl_t HACK_Y         = 6'b110000;
  localparam ctl_t HACK_NOT_X     = 6'b001101;
  localparam ctl_t HACK_X_PLUS_Y  = 6'b000010;
  localparam ctl_t HACK_X_MINUS_Y = 6'b010011;
  localparam ctl_t HACK_Y_MINUS_X = 6'b000111;
  localparam ctl_t HACK_X_AND_Y   = 6'b000000;
  localparam ctl_t HACK_X_OR_Y    = 6'b010101;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/control input beat and result/flag output beat of alu_pipe,
// each with a valid/ready handshake.
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, zx, nx, zy, ny, f, no, x, y, out_ready,
    output in_ready, out_valid, out, zr, ng, cout, ovf
  );

  modport master (
    output in_valid, zx, nx, zy, ny, f, no, x, y, out_ready,
    input  in_ready, out_valid, out, zr, ng, cout, ovf
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU body: add or AND of the pre-processed operands, optional
// output inversion, and carry/overflow of the raw sum.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] xp,
  input  logic [WIDTH-1:0] yp,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw;

  assign sum = {1'b0, xp} + {1'b0, yp};
  assign raw = f ? sum[WIDTH-1:0] : (xp & yp);
  assign res = no ? ~raw : raw;

  // Carry and overflow describe the sum itself, so they ignore the no inversion.
  assign cout = f & sum[WIDTH];
  assign ovf  = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum[WIDTH-1] != xp[WIDTH-1]);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage Hack ALU pipeline: stage 1 registers pre-processed operands,
// stage 2 registers the result and flags; both stages backpressure-aware.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);

  logic [WIDTH-1:0] x_pre;
  logic [WIDTH-1:0] y_pre;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_x_reg;
  logic [WIDTH-1:0] s1_y_reg;
  logic             s1_f_reg;
  logic             s1_no_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] out_reg;
  logic             zr_reg;
  logic             ng_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] core_res;
  logic             core_cout;
  logic             core_ovf;

  logic             s1_load;
  logic             s2_load;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pre
    assign x_pre[gi] = (bus.x[gi] & ~bus.zx) ^ bus.nx;
    assign y_pre[gi] = (bus.y[gi] & ~bus.zy) ^ bus.ny;
  end

  // A full stage can still load when the stage ahead of it drains this cycle.
  assign s2_load = !s2_valid_reg || bus.out_ready;
  assign s1_load = !s1_valid_reg || s2_load;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .xp   (s1_x_reg),
    .yp   (s1_y_reg),
    .f    (s1_f_reg),
    .no   (s1_no_reg),
    .res  (core_res),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      out_reg      <= '0;
      zr_reg       <= 1'b0;
      ng_reg       <= 1'b0;
      cout_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= bus.in_valid;
        if (bus.in_valid) begin
          s1_x_reg  <= x_pre;
          s1_y_reg  <= y_pre;
          s1_f_reg  <= bus.f;
          s1_no_reg <= bus.no;
        end
      end
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_reg  <= core_res;
          zr_reg   <= (core_res == '0);
          ng_reg   <= core_res[WIDTH-1];
          cout_reg <= core_cout;
          ovf_reg  <= core_ovf;
        end
      end
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_reg;
  assign bus.out       = out_reg;
  assign bus.zr        = zr_reg;
  assign bus.ng        = ng_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: streamed vector table at WIDTH=16, then
// backpressure, mid-flight reset and a WIDTH=8 overflow case.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk;
  logic rst;

  alu_pipe_if #(.WIDTH(16)) b16 ();
  alu_pipe_if #(.WIDTH(8))  b8 ();

  alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    ctl_t        ctl;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] eo;
    logic        ezr;
    logic        eng;
    logic        ecout;
    logic        eovf;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive16(input logic v, input ctl_t c, input logic [15:0] xv, input logic [15:0] yv);
    b16.in_valid = v;
    b16.zx = c[CTL_ZX];
    b16.nx = c[CTL_NX];
    b16.zy = c[CTL_ZY];
    b16.ny = c[CTL_NY];
    b16.f  = c[CTL_F];
    b16.no = c[CTL_NO];
    b16.x  = xv;
    b16.y  = yv;
  endtask

  task automatic drive8(input logic v, input ctl_t c, input logic [7:0] xv, input logic [7:0] yv);
    b8.in_valid = v;
    b8.zx = c[CTL_ZX];
    b8.nx = c[CTL_NX];
    b8.zy = c[CTL_ZY];
    b8.ny = c[CTL_NY];
    b8.f  = c[CTL_F];
    b8.no = c[CTL_NO];
    b8.x  = xv;
    b8.y  = yv;
  endtask

  task automatic check_vec(input int i);
    check($sformatf("vec%0d_out", i),  64'(b16.out),  64'(vecs[i].eo));
    check($sformatf("vec%0d_zr", i),   64'(b16.zr),   64'(vecs[i].ezr));
    check($sformatf("vec%0d_ng", i),   64'(b16.ng),   64'(vecs[i].eng));
    check($sformatf("vec%0d_cout", i), 64'(b16.cout), 64'(vecs[i].ecout));
    check($sformatf("vec%0d_ovf", i),  64'(b16.ovf),  64'(vecs[i].eovf));
    $display("[TB] vec%0d ctl=%b x=%04h y=%04h -> out=%04h zr=%0d ng=%0d cout=%0d ovf=%0d",
             i, vecs[i].ctl, vecs[i].x, vecs[i].y, b16.out, b16.zr, b16.ng, b16.cout, b16.ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oidx;
    int sent;
    int ghosts;
    bit seen8;

    //              ctl             x        y        out      zr ng co ov
    vecs[0]  = '{HACK_ZERO,      16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 0};
    vecs[1]  = '{HACK_ONE,       16'h0005, 16'h0005, 16'h0001, 0, 0, 1, 0};
    vecs[2]  = '{HACK_NEG_ONE,   16'h0005, 16'h0005, 16'hFFFF, 0, 1, 0, 0};
    vecs[3]  = '{HACK_X_PLUS_Y,  16'd10,   16'd5,    16'd15,   0, 0, 0, 0};
    vecs[4]  = '{HACK_X_PLUS_Y,  16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0};
    vecs[5]  = '{HACK_X_PLUS_Y,  16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1};
    vecs[6]  = '{HACK_X_AND_Y,   16'h0F0F, 16'h00FF, 16'h000F, 0, 0, 0, 0};
    vecs[7]  = '{HACK_X,         16'h1234, 16'hABCD, 16'h1234, 0, 0, 0, 0};
    vecs[8]  = '{HACK_X_MINUS_Y, 16'd5,    16'd7,    16'hFFFE, 0, 1, 1, 0};
    vecs[9]  = '{HACK_Y_MINUS_X, 16'd3,    16'd8,    16'h0005, 0, 0, 0, 0};
    vecs[10] = '{HACK_X_PLUS_Y,  16'h8000, 16'h8000, 16'h0000, 1, 0, 1, 1};
    vecs[11] = '{HACK_X_OR_Y,    16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0, 0};

    rst = 1'b1;
    drive16(1'b0, HACK_ZERO, 16'h0, 16'h0);
    drive8(1'b0, HACK_ZERO, 8'h0, 8'h0);
    b16.out_ready = 1'b1;
    b8.out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(b16.out_valid), 64'd0);
    check("reset_out",       64'(b16.out),       64'd0);
    check("reset_flags",     64'({b16.zr, b16.ng, b16.cout, b16.ovf}), 64'd0);
    check("reset_in_ready",  64'(b16.in_ready),  64'd1);
    $display("[TB] reset: out_valid=%0d out=%04h in_ready=%0d", b16.out_valid, b16.out, b16.in_ready);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream through the vector table with downstream always ready.
    oidx = 0;
    for (int c = 0; c < NV + 6; c++) begin
      @(negedge clk);
      if (c < NV) drive16(1'b1, vecs[c].ctl, vecs[c].x, vecs[c].y);
      else        drive16(1'b0, HACK_ZERO, 16'h0, 16'h0);
      #1;
      if (c < NV) check($sformatf("stream_in_ready%0d", c), 64'(b16.in_ready), 64'd1);
      if (c == 1) check("latency_gap",   64'(b16.out_valid), 64'd0);
      if (c == 2) check("latency_first", 64'(b16.out_valid), 64'd1);
      if (b16.out_valid) begin
        if (oidx < NV) check_vec(oidx);
        else check("stream_extra_result", 64'd1, 64'd0);
        oidx++;
      end
    end
    check("stream_count", 64'(oidx), 64'(NV));

    // Backpressure: four beats offered against a stalled output.
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      b16.out_ready = 1'b0;
      if (sent < 4) drive16(1'b1, HACK_X_PLUS_Y, 16'(sent + 1), 16'h0);
      else          drive16(1'b0, HACK_ZERO, 16'h0, 16'h0);
      #1;
      if (c >= 2) begin
        check($sformatf("stall_in_ready%0d", c),  64'(b16.in_ready),  64'd0);
        check($sformatf("stall_out_valid%0d", c), 64'(b16.out_valid), 64'd1);
        check($sformatf("stall_out%0d", c),       64'(b16.out),       64'd1);
      end
      if (b16.in_valid && b16.in_ready) sent++;
      $display("[TB] stall cycle %0d: accepted=%0d out_valid=%0d out=%04h", c, sent, b16.out_valid, b16.out);
    end
    check("stall_accepted", 64'(sent), 64'd2);

    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      b16.out_ready = 1'b1;
      if (sent < 4) drive16(1'b1, HACK_X_PLUS_Y, 16'(sent + 1), 16'h0);
      else          drive16(1'b0, HACK_ZERO, 16'h0, 16'h0);
      #1;
      check($sformatf("release_valid%0d", j), 64'(b16.out_valid), 64'd1);
      check($sformatf("release_out%0d", j),   64'(b16.out),       64'(j + 1));
      if (b16.in_valid && b16.in_ready) sent++;
      $display("[TB] release %0d: out_valid=%0d out=%04h", j, b16.out_valid, b16.out);
    end
    @(negedge clk);
    drive16(1'b0, HACK_ZERO, 16'h0, 16'h0);
    #1;
    check("release_drained", 64'(b16.out_valid), 64'd0);
    check("release_sent",    64'(sent),          64'd4);

    // Mid-flight reset with a beat offered during the reset cycle.
    @(negedge clk);
    b16.out_ready = 1'b0;
    drive16(1'b1, HACK_X_PLUS_Y, 16'h0011, 16'h0);
    #1;
    check("flight_acc0", 64'(b16.in_ready), 64'd1);
    @(negedge clk);
    drive16(1'b1, HACK_X_PLUS_Y, 16'h0022, 16'h0);
    #1;
    check("flight_acc1", 64'(b16.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    drive16(1'b1, HACK_X_PLUS_Y, 16'h0033, 16'h0);
    @(posedge clk);
    #1;
    check("flight_rst_in_ready",  64'(b16.in_ready),  64'd1);
    check("flight_rst_out_valid", 64'(b16.out_valid), 64'd0);
    check("flight_rst_out",       64'(b16.out),       64'd0);
    check("flight_rst_flags",     64'({b16.zr, b16.ng, b16.cout, b16.ovf}), 64'd0);
    $display("[TB] reset mid-flight: out_valid=%0d out=%04h", b16.out_valid, b16.out);
    @(negedge clk);
    rst = 1'b0;
    b16.out_ready = 1'b1;
    drive16(1'b0, HACK_ZERO, 16'h0, 16'h0);
    ghosts = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (b16.out_valid) ghosts++;
    end
    check("flight_no_ghosts", 64'(ghosts), 64'd0);

    // Recovery after reset plus the WIDTH=8 overflow case.
    @(negedge clk);
    drive16(1'b1, HACK_X_PLUS_Y, 16'h0009, 16'h0003);
    drive8(1'b1, HACK_X_PLUS_Y, 8'h7F, 8'h01);
    @(negedge clk);
    drive16(1'b0, HACK_ZERO, 16'h0, 16'h0);
    drive8(1'b0, HACK_ZERO, 8'h0, 8'h0);
    seen8 = 1'b0;
    for (int c = 0; c < 5 && !seen8; c++) begin
      #1;
      if (b8.out_valid) begin
        seen8 = 1'b1;
        check("w8_out",  64'(b8.out),  64'h80);
        check("w8_ovf",  64'(b8.ovf),  64'd1);
        check("w8_ng",   64'(b8.ng),   64'd1);
        check("w8_cout", 64'(b8.cout), 64'd0);
        check("w16_recover_valid", 64'(b16.out_valid), 64'd1);
        check("w16_recover_out",   64'(b16.out),       64'd12);
        $display("[TB] w8: out=%02h ovf=%0d ng=%0d; w16 recover out=%04h", b8.out, b8.ovf, b8.ng, b16.out);
      end
      @(negedge clk);
    end
    check("w8_seen", 64'(seen8), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits, legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand/control beat offered.
REQ-005 in_ready  output  1  block accepts the beat this cycle.
REQ-006 zx, nx, zy, ny, f, no  input  1 each  control bits: zero x, negate x, zero y, negate y, f=1 add / f=0 AND, negate output.
REQ-007 x, y  input  WIDTH each  operands.
REQ-008 out_valid  output  1  result beat present.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out  output  WIDTH  result.
REQ-011 zr, ng, cout, ovf  output  1 each  flags: result zero; result MSB; carry out of add; signed overflow of add.

Function
REQ-012 The block SHALL accept a beat when in_valid && in_ready are both high at a rising edge. It SHALL present a result when out_valid && out_ready are both high.
REQ-013 Stage 1 SHALL register x'=(zx?0:x), then bitwise-inverted if nx. It SHALL register y' the same way using zy/ny. It SHALL also register f and no.
REQ-014 Stage 2 SHALL register r=(f ? x'+y' : x'&y'), then bitwise-inverted if no. The result SHALL be truncated to WIDTH bits and driven on out.
REQ-015 cout SHALL be the carry out of x'+y' when f=1, else 0. cout is taken before any no inversion.
REQ-016 ovf SHALL be 1 when f=1 and x', y' have equal MSBs that differ from the MSB of the sum, else 0. ovf is taken before any no inversion.
REQ-017 zr SHALL equal (out==0). ng SHALL equal out[WIDTH-1]. Both are computed on the final, post-no value.
REQ-018 Latency SHALL be 2 cycles: a beat accepted at edge N gives out_valid=1 after edge N+2, provided no stall occurs.
REQ-019 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-020 Stage 2 SHALL load when !s2_valid || out_ready. Stage 1 SHALL load when !s1_valid || (stage-2 load).
REQ-021 in_ready SHALL equal the stage-1 load enable. It is combinational from out_ready; there is no path from in_valid to in_ready.
REQ-022 While out_valid=1 and out_ready=0, out and all flags SHALL hold stable.
REQ-023 Results SHALL leave in acceptance order. No beat SHALL be dropped or duplicated.
REQ-024 Simultaneous pop of stage 2 and push of stage 1 in the same cycle SHALL be lossless.
REQ-025 Beats with in_valid=0 SHALL NOT alter any stage. Stage data registers may retain stale values while their valid bit is 0.

Reset
REQ-026 With rst=1 at an edge, s1_valid and s2_valid SHALL clear to 0.
REQ-027 With rst=1 at an edge, out, zr, ng, cout and ovf SHALL clear to 0.
REQ-028 While rst=1, in_ready SHALL read 1 after the first reset edge.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight beats. No partial result SHALL appear after reset deasserts.
REQ-030 A beat offered in the same cycle as rst=1 SHALL NOT be accepted.

Structure
REQ-031 Shared package alu_pkg SHALL hold DEFAULT_WIDTH=16. It SHALL also hold the 6-bit control-word field positions (zx..no, MSB first) and named constants for the Hack control codes used in verification.
REQ-032 The datapath SHALL use one combinational sub-module, alu_core (WIDTH parameter). It takes pre-processed x', y', f, no and returns the result, cout and ovf. The pipeline registers and handshake live in alu_pipe.

Verification
REQ-033 WIDTH=16, x=5, y=5, control 101010 → out=0x0000, zr=1, ng=0, cout=0; control 111111 → out=0x0001.
REQ-034 Control 111010 → out=0xFFFF, ng=1, zr=0.
REQ-035 Control 000010 with x=10, y=5 → out=15.
REQ-036 Control 000010 with x=0xFFFF, y=1 → out=0, zr=1, cout=1, ovf=0.
REQ-037 Control 000010 with x=0x7FFF, y=1 → out=0x8000, ng=1, ovf=1, cout=0.
REQ-038 Backpressure: hold out_ready=0 and offer 4 consecutive beats (x=1..4, y=0, control 000010). Required: exactly 2 beats accepted and in_ready=0 afterwards. Then set out_ready=1: outputs 1, 2, 3, 4 in order, one per cycle, with out stable throughout the stall.
REQ-039 Reset mid-flight: accept 2 beats, then assert rst for 1 cycle. Required: out_valid=0 and all outputs 0 on the next cycle, and no result for those beats ever appears.
REQ-040 WIDTH=8 rerun with x=0x7F, y=1, control 000010 → out=0x80, ovf=1.
